pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 28 ++
 rtl/pc_tag_fifo.sv | 73 +++++++
 rtl/pc_sequencer.sv | 115 +++++++++++
 tb/tb_pc_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch PC sequencer: FSM states, tag-FIFO slot layout
// and the slot-index wrap helper.
package pc_seq_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
    logic        discard;
  } slot_t;

  // Ring index (base + off) mod depth; depth is at most 4 so two bits suffice.
  function automatic logic [1:0] slot_idx(input logic [1:0] base, input logic [2:0] off,
                                          input int depth);
    int sum;
    sum = int'(base) + int'(off);
    return 2'(sum % depth);
  endfunction

endpackage

// File: rtl/pc_tag_fifo.sv
// In-order tag FIFO of outstanding fetches: alloc at tail, fill oldest unfilled,
// pop at head, and bulk discard on redirect.
module pc_tag_fifo
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        alloc,
  input  logic [31:0] alloc_pc,
  input  logic        alloc_discard,
  input  logic        fill,
  input  logic [31:0] fill_data,
  input  logic        pop,
  input  logic        discard_all,
  output logic        full,
  output logic        empty,
  output slot_t       head
);

  slot_t       slots [4];
  logic [1:0]  head_idx;
  logic [1:0]  tail_idx;
  logic [1:0]  fill_idx;
  logic [2:0]  count;
  logic        fill_hit;
  logic        do_pop;
  logic        do_alloc;

  // Responses arrive in order, so filled slots form a prefix from the head;
  // scanning downward leaves the oldest unfilled allocated slot selected.
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = head_idx;
    for (int i = 3; i >= 0; i--) begin
      if (3'(i) < count && !slots[slot_idx(head_idx, 3'(i), DEPTH)].filled) begin
        fill_hit = 1'b1;
        fill_idx = slot_idx(head_idx, 3'(i), DEPTH);
      end
    end
  end

  assign tail_idx = slot_idx(head_idx, count, DEPTH);
  assign empty    = (count == 3'd0);
  assign full     = (count == 3'(DEPTH));
  assign head     = empty ? '0 : slots[head_idx];
  assign do_alloc = alloc && !full;
  // Filled discard slots retire on their own; live slots wait for the consumer.
  assign do_pop   = !empty && slots[head_idx].filled && (pop || slots[head_idx].discard);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_idx <= '0;
      count    <= '0;
      for (int i = 0; i < 4; i++) slots[i] <= '0;
    end else begin
      if (fill && fill_hit) begin
        slots[fill_idx].instr  <= fill_data;
        slots[fill_idx].filled <= 1'b1;
      end
      if (discard_all) begin
        for (int i = 0; i < 4; i++) slots[i].discard <= 1'b1;
      end
      if (do_alloc) begin
        slots[tail_idx] <= '{pc: alloc_pc, instr: '0, filled: 1'b0, discard: alloc_discard};
      end
      if (do_pop) head_idx <= slot_idx(head_idx, 3'd1, DEPTH);
      count <= count + 3'(do_alloc) - 3'(do_pop);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/DRAIN FSM, PC register and redirect handling.
// Optional misaligned-branch trap enabled by defining MISALIGN_TRAP_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010,
  parameter int          DEPTH        = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_pc_in,
  output logic        imem_req_valid_out,
  input  logic        imem_req_ready_in,
  output logic [31:0] imem_addr_out,
  input  logic        imem_resp_valid_in,
  input  logic [31:0] imem_resp_data_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        flush_out,
  output logic        misalign_trap_out
);

  localparam logic [31:0] ALIGN_MASK = 32'(INSTR_BYTES - 1);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pc_sequencer: DEPTH must be in 1..4");
  end
  if (TRAP_VECTOR[1:0] != 2'b00) begin : g_bad_trap
    $error("pc_sequencer: TRAP_VECTOR must be word aligned");
  end

  state_t      state;
  logic [31:0] pc;
  logic [31:0] target;
  logic        redirect;
  logic        handshake;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  slot_t       head;

  assign redirect           = branch_taken_in && (state != BOOT);
  assign imem_req_valid_out = (state == RUN) && !fifo_full;
  assign imem_addr_out      = pc;
  assign handshake          = imem_req_valid_out && imem_req_ready_in;
  assign instr_valid_out    = head.filled && !head.discard;
  assign instr_out          = instr_valid_out ? head.instr : '0;
  assign instr_pc_out       = instr_valid_out ? head.pc : '0;
  assign pop                = instr_valid_out && !stall_in && !redirect;

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  logic trap_q;

  assign misaligned        = (branch_pc_in[1:0] != 2'b00);
  assign target            = misaligned ? TRAP_VECTOR : (branch_pc_in & ~ALIGN_MASK);
  assign misalign_trap_out = trap_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) trap_q <= 1'b0;
    else          trap_q <= redirect && misaligned;
  end
`else
  assign target            = branch_pc_in & ~ALIGN_MASK;
  assign misalign_trap_out = 1'b0;
`endif

  // A redirect beats both the +4 advance and a waiting pop; a repeat redirect
  // while draining just retargets.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= BOOT;
      pc        <= RESET_VECTOR;
      flush_out <= 1'b0;
    end else begin
      flush_out <= redirect;
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (redirect) begin
            pc    <= target;
            state <= DRAIN;
          end else if (handshake) begin
            pc <= pc + 32'(INSTR_BYTES);
          end
        end
        DRAIN: begin
          if (redirect)        pc    <= target;
          else if (fifo_empty) state <= RUN;
        end
        default: state <= BOOT;
      endcase
    end
  end

  pc_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .alloc        (handshake),
    .alloc_pc     (pc),
    .alloc_discard(redirect),
    .fill         (imem_resp_valid_in),
    .fill_data    (imem_resp_data_in),
    .pop          (pop),
    .discard_all  (redirect),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .head         (head)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer: a memory responder drives
// in-order replies, a negedge monitor checks against a queue-based fetch model.
module tb_pc_sequencer;

  localparam logic [31:0] RV    = 32'h0000_0100;
  localparam logic [31:0] TV    = 32'h0000_0010;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_in = 1'b0;
  logic        branch_taken_in = 1'b0;
  logic [31:0] branch_pc_in = '0;
  logic        imem_req_valid_out;
  logic        imem_req_ready_in = 1'b0;
  logic [31:0] imem_addr_out;
  logic        imem_resp_valid_in = 1'b0;
  logic [31:0] imem_resp_data_in = '0;
  logic        instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        flush_out;
  logic        misalign_trap_out;

  pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .stall_in          (stall_in),
    .branch_taken_in   (branch_taken_in),
    .branch_pc_in      (branch_pc_in),
    .imem_req_valid_out(imem_req_valid_out),
    .imem_req_ready_in (imem_req_ready_in),
    .imem_addr_out     (imem_addr_out),
    .imem_resp_valid_in(imem_resp_valid_in),
    .imem_resp_data_in (imem_resp_data_in),
    .instr_valid_out   (instr_valid_out),
    .instr_out         (instr_out),
    .instr_pc_out      (instr_pc_out),
    .flush_out         (flush_out),
    .misalign_trap_out (misalign_trap_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory image: word at RV is 0xA, next is 0xB, and so on.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a - RV) >> 2) + 32'hA;
  endfunction

  function automatic logic [31:0] exp_target(input logic [31:0] b);
`ifdef MISALIGN_TRAP_EN
    if (b % 4 != 0) return TV;
`endif
    return b - (b % 4);
  endfunction

  function automatic bit exp_trap(input logic [31:0] b);
`ifdef MISALIGN_TRAP_EN
    return (b % 4 != 0);
`else
    return (b != b);
`endif
  endfunction

  // ---------------- reference model / monitor ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_pc = RV;
  logic [31:0] last_hs_addr = '0;
  logic [31:0] prev_addr = '0;
  int          outstanding = 0;
  int          hs_total = 0;
  int          drain_wait = 0;
  int          m_occ;
  bit          m_redir;
  bit          in_boot = 1'b1;
  bit          draining = 1'b0;
  bit          flush_exp = 1'b0;
  bit          trap_exp = 1'b0;
  bit          prev_hold = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      exp_pc     = RV;
      outstanding = 0;
      in_boot    = 1'b1;
      draining   = 1'b0;
      flush_exp  = 1'b0;
      trap_exp   = 1'b0;
      prev_hold  = 1'b0;
      drain_wait = 0;
    end else begin
      check("flush", flush_out, flush_exp);
      check("trap", misalign_trap_out, trap_exp);
      m_redir = branch_taken_in && !in_boot;
      m_occ   = exp_q.size();
      if (in_boot) check("boot_req", imem_req_valid_out, 1'b0);
      if (prev_hold) begin
        check("hold_valid", imem_req_valid_out, 1'b1);
        check("hold_addr", imem_addr_out, prev_addr);
      end
      if (instr_valid_out) begin
        if (exp_q.size() == 0) check("spurious_instr", instr_valid_out, 1'b0);
        else begin
          check("instr_pc", instr_pc_out, exp_q[0].pc);
          check("instr", instr_out, exp_q[0].instr);
          if (!stall_in && !m_redir) void'(exp_q.pop_front());
        end
      end
      if (imem_resp_valid_in && outstanding > 0) outstanding--;
      if (draining && imem_req_valid_out) begin
        check("drain_outstanding", outstanding, 0);
        draining = 1'b0;
      end
      if (!draining && !in_boot) check("req_valid", imem_req_valid_out, m_occ < DEPTH);
      if (imem_req_valid_out) begin
        check("req_addr", imem_addr_out, exp_pc);
        if (imem_req_ready_in) begin
          hs_total++;
          outstanding++;
          last_hs_addr = imem_addr_out;
          if (!m_redir) exp_q.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
          exp_pc = exp_pc + 4;
        end
      end
      if (draining && outstanding == 0 && !m_redir) begin
        drain_wait++;
        if (drain_wait > 4) check("drain_exit", imem_req_valid_out, 1'b1);
      end
      prev_hold = imem_req_valid_out && !imem_req_ready_in && !m_redir;
      prev_addr = imem_addr_out;
      if (m_redir) begin
        exp_q.delete();
        exp_pc     = exp_target(branch_pc_in);
        flush_exp  = 1'b1;
        trap_exp   = exp_trap(branch_pc_in);
        draining   = 1'b1;
        drain_wait = 0;
      end else begin
        flush_exp = 1'b0;
        trap_exp  = 1'b0;
      end
      in_boot = 1'b0;
    end
  end

  // ---------------- memory responder / stimulus ----------------
  logic [31:0] mem_q[$];
  bit          resp_en = 1'b1;
  bit          resp_real = 1'b0;
  int          resp_pct = 100;
  int          stale = 0;

  task automatic tick();
    @(negedge clk);
    if (reset_n) begin
      if (resp_real && mem_q.size() > 0) void'(mem_q.pop_front());
      if (imem_req_valid_out && imem_req_ready_in) mem_q.push_back(imem_addr_out);
    end
    @(posedge clk);
    #1;
    resp_real = 1'b0;
    if (stale > 0) begin
      stale--;
      imem_resp_valid_in = 1'b1;
      imem_resp_data_in  = 32'hDEAD_BEEF;
    end else if (resp_en && mem_q.size() > 0 && $urandom_range(99) < resp_pct) begin
      imem_resp_valid_in = 1'b1;
      imem_resp_data_in  = mem_word(mem_q[0]);
      resp_real          = 1'b1;
    end else begin
      imem_resp_valid_in = 1'b0;
      imem_resp_data_in  = $urandom;
    end
  endtask

  task automatic wait_hs(input int n);
    int start;
    start = hs_total;
    for (int i = 0; i < 40 && hs_total < start + n; i++) tick();
    check("hs_timeout", hs_total >= start + n, 1'b1);
  endtask

  task automatic redirect_to(input logic [31:0] b);
    branch_taken_in = 1'b1;
    branch_pc_in    = b;
    tick();
    branch_taken_in = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_valid", imem_req_valid_out, 1'b0);
    check("rst_addr", imem_addr_out, RV);
    check("rst_instr_valid", instr_valid_out, 1'b0);
    check("rst_instr", instr_out, 32'h0);
    check("rst_instr_pc", instr_pc_out, 32'h0);
    check("rst_flush", flush_out, 1'b0);
    check("rst_trap", misalign_trap_out, 1'b0);
  endtask

  initial begin
    // Reset, then fetch under a stalled decode until the FIFO is full.
    imem_req_ready_in = 1'b1;
    stall_in          = 1'b1;
    #12;
    check_reset_outputs();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("fill_to_depth", hs_total, DEPTH);
    check("stall_hold_instr", instr_out, 32'hA);
    check("stall_hold_pc", instr_pc_out, RV);
    stall_in = 1'b0;
    tick();
    check("second_instr", instr_out, 32'hB);
    check("second_pc", instr_pc_out, RV + 4);

    // Two fetches outstanding, then redirect to 0x200 while replies are held.
    imem_req_ready_in = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    resp_en           = 1'b0;
    imem_req_ready_in = 1'b1;
    for (int i = 0; i < 20 && outstanding < 2; i++) tick();
    check("two_outstanding", outstanding >= 2, 1'b1);
    imem_req_ready_in = 1'b0;
    redirect_to(32'h200);
    imem_req_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("drain_no_req", imem_req_valid_out, 1'b0);
    resp_en = 1'b1;
    wait_hs(1);
    check("redirect_addr", last_hs_addr, 32'h200);

    // Redirect under stall, then a second redirect while draining.
    stall_in = 1'b1;
    for (int i = 0; i < 10 && !instr_valid_out; i++) tick();
    check("head_before_redirect", instr_valid_out, 1'b1);
    resp_en = 1'b0;
    redirect_to(32'h250);
    check("flush_pulse", flush_out, 1'b1);
    check("killed_instr", instr_valid_out, 1'b0);
    redirect_to(32'h300);
    stall_in = 1'b0;
    resp_en  = 1'b1;
    wait_hs(1);
    check("second_redirect_addr", last_hs_addr, 32'h300);

    // Misaligned target.
    for (int i = 0; i < 3; i++) tick();
    redirect_to(32'h202);
    check("misalign_trap", misalign_trap_out, exp_trap(32'h202));
    wait_hs(1);
    check("misalign_addr", last_hs_addr, exp_target(32'h202));

    // Address wrap at the top of memory.
    for (int i = 0; i < 3; i++) tick();
    redirect_to(32'hFFFF_FFFC);
    wait_hs(2);
    check("wrap_addr", last_hs_addr, 32'h0);

    // Randomized traffic.
    resp_pct = 60;
    for (int i = 0; i < 1500; i++) begin
      stall_in          = ($urandom_range(9) < 3);
      imem_req_ready_in = ($urandom_range(9) < 7);
      branch_taken_in   = ($urandom_range(19) == 0);
      branch_pc_in      = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      tick();
    end
    branch_taken_in = 1'b0;

    // Reset in the middle of outstanding fetches; stale replies must vanish.
    resp_pct          = 100;
    resp_en           = 1'b0;
    stall_in          = 1'b0;
    imem_req_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    mem_q.delete();
    resp_real          = 1'b0;
    imem_resp_valid_in = 1'b0;
    @(posedge clk);
    #1;
    reset_n            = 1'b1;
    imem_resp_valid_in = 1'b1;
    imem_resp_data_in  = 32'hDEAD_BEEF;
    stale              = 1;
    resp_en            = 1'b1;
    wait_hs(1);
    for (int i = 0; i < 10 && !instr_valid_out; i++) tick();
    check("post_reset_instr", instr_out, 32'hA);
    check("post_reset_pc", instr_pc_out, RV);

    // Drain everything and confirm nothing was lost.
    imem_req_ready_in = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("final_exp_empty", exp_q.size(), 0);
    check("final_outstanding", outstanding, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
